// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter: FSM state encoding and gate-counter sizing.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int gate_cnt_width(input int gate_cycles);
    int w;
    w = $clog2(gate_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings an asynchronous clock into clk_i's domain and flags each rising edge for one cycle.
module freq_meter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
  assign hist_d = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Counts meas_clk_i rising edges over a window of GATE_CYCLES clk_i cycles.
// Define FREQ_METER_CONTINUOUS_EN to rearm the window automatically after every result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   meas_clk_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   overflow_o
);

  localparam int                     GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0]          GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  state_e                 state_q, state_d;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   rise;

  freq_meter_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(meas_clk_i),
    .rise_o (rise)
  );

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = GATE;
          gate_cnt_d = GATE_LOAD;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      GATE: begin
        // The final gate cycle still counts its edge before handing over to DONE.
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
          end
        end
        if (gate_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          gate_cnt_d = gate_cnt_q - GW'(1);
        end
      end
      DONE: begin
        count_d    = edge_cnt_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
        state_d    = GATE;
        gate_cnt_d = GATE_LOAD;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
`else
        state_d    = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
